// File: rtl/fmdll_pkg.sv
// Shared widths, ratio limits and request clamping for the FMDLL divider and select stages.
package fmdll_pkg;

  localparam int N_W = 4;
  localparam int M_W = 2;
  localparam logic [N_W-1:0] N_MIN = 4'd2;
  localparam logic [M_W-1:0] M_MIN = 2'd1;

  typedef struct packed {
    logic [N_W-1:0] n;
    logic [M_W-1:0] m;
  } cfg_t;

  // Ratios below the minimum would make the counters degenerate, so they are raised to it.
  function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] n);
    return (n < N_MIN) ? N_MIN : n;
  endfunction

  function automatic logic [M_W-1:0] clamp_m(input logic [M_W-1:0] m);
    return (m < M_MIN) ? M_MIN : m;
  endfunction

endpackage

// File: rtl/fmdll_mod_counter.sv
// Position counter running 1..limit; wrap flags the increment that returns it to 1.
module fmdll_mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  // Wrapping on >= keeps the count in range even if the limit were ever below it.
  always_comb begin
    wrap       = inc && (count >= limit);
    count_next = count;
    if (clear || wrap) begin
      count_next = W'(1);
    end else if (inc) begin
      count_next = count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= W'(1);
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/fmdll_div_counter.sv
// Frame divider: N/M position counters, divided clocks and boundary-aligned ratio updates.
module fmdll_div_counter
  import fmdll_pkg::*;
#(
  parameter int N_DEF = 4,
  parameter int M_DEF = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [N_W-1:0] N_cfg,
  input  logic [M_W-1:0] M_cfg,
  output logic [N_W-1:0] N,
  output logic [M_W-1:0] M,
  output logic [N_W-1:0] N_counter,
  output logic [M_W-1:0] M_counter,
  output logic           DIV_N,
  output logic           DIV_M,
  output logic           frame_start
);

  cfg_t           pend;
  logic           parked;
  logic           counting;
  logic           n_wrap;
  logic           m_wrap;
  logic           capture;
  logic           load;
  logic [N_W-1:0] n_count_next;
  logic [M_W-1:0] m_count_next;
  logic [N_W-1:0] n_act_next;
  logic [M_W-1:0] m_act_next;
  logic [N_W:0]   n_half;
  logic [M_W:0]   m_half;

  // After a park the first enabled edge only announces the frame; counting starts one edge later.
  assign counting = en && !parked;

  fmdll_mod_counter #(.W(N_W)) u_n_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!en),
    .inc        (counting),
    .limit      (N),
    .count      (N_counter),
    .count_next (n_count_next),
    .wrap       (n_wrap)
  );

  fmdll_mod_counter #(.W(M_W)) u_m_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!en),
    .inc        (n_wrap),
    .limit      (M),
    .count      (M_counter),
    .count_next (m_count_next),
    .wrap       (m_wrap)
  );

  // cfg_ready low doubles as "pending request held"; it applies when the counters return to (1,1).
  assign capture    = cfg_valid && cfg_ready;
  assign load       = !cfg_ready && (!en || m_wrap);
  assign n_act_next = load ? pend.n : N;
  assign m_act_next = load ? pend.m : M;
  assign n_half     = ({1'b0, n_act_next} + (N_W+1)'(1)) >> 1;
  assign m_half     = ({1'b0, m_act_next} + (M_W+1)'(1)) >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      N           <= N_W'(N_DEF);
      M           <= M_W'(M_DEF);
      pend        <= '0;
      cfg_ready   <= 1'b1;
      parked      <= 1'b0;
      DIV_N       <= 1'b1;
      DIV_M       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (capture) begin
        pend      <= '{n: clamp_n(N_cfg), m: clamp_m(M_cfg)};
        cfg_ready <= 1'b0;
      end else if (load) begin
        N         <= pend.n;
        M         <= pend.m;
        cfg_ready <= 1'b1;
      end
      parked      <= !en;
      frame_start <= en && (parked || m_wrap);
      DIV_N       <= ({1'b0, n_count_next} <= n_half);
      DIV_M       <= ({1'b0, m_count_next} <= m_half);
    end
  end

endmodule

// File: tb/tb_fmdll_div_counter.sv
// Directed bench for fmdll_div_counter: default framing, ratio updates, clamping, enable and reset.
module tb_fmdll_div_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] N_cfg;
  logic [1:0] M_cfg;
  logic [3:0] N;
  logic [1:0] M;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N;
  logic       DIV_M;
  logic       frame_start;

  int checks = 0;
  int fails  = 0;

  fmdll_div_counter #(.N_DEF(4), .M_DEF(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .N_cfg       (N_cfg),
    .M_cfg       (M_cfg),
    .N           (N),
    .M           (M),
    .N_counter   (N_counter),
    .M_counter   (M_counter),
    .DIV_N       (DIV_N),
    .DIV_M       (DIV_M),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Divided-clock expectations follow directly from the ratio and position being checked.
  task automatic checkFrame(input string tag, input int n, input int m, input int nc, input int mc,
                            input int fs);
    checkOutput({tag, "_N"}, int'(N), n);
    checkOutput({tag, "_M"}, int'(M), m);
    checkOutput({tag, "_Ncnt"}, int'(N_counter), nc);
    checkOutput({tag, "_Mcnt"}, int'(M_counter), mc);
    checkOutput({tag, "_DIVN"}, int'(DIV_N), int'(nc <= (n + 1) / 2));
    checkOutput({tag, "_DIVM"}, int'(DIV_M), int'(mc <= (m + 1) / 2));
    checkOutput({tag, "_fs"}, int'(frame_start), fs);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] nq, input logic [1:0] mq,
                               input logic e, input logic r);
    cfg_valid = v;
    N_cfg     = nq;
    M_cfg     = mq;
    en        = e;
    rst_n     = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    repeat (2) tick();
    checkFrame("reset", 4, 2, 1, 1, 0);
    checkOutput("reset_ready", int'(cfg_ready), 1);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);

    for (int i = 1; i <= 16; i++) begin
      tick();
      checkFrame($sformatf("def_%0d", i), 4, 2, i % 4 + 1, (i / 4) % 2 + 1, int'(i % 8 == 0));
    end

    // Mid-frame request at (2,1): old frame finishes, then N=6/M=3 frames of 18.
    tick();
    checkFrame("req_pos", 4, 2, 2, 1, 0);
    applyStimulus(1'b1, 4'd6, 2'd3, 1'b1, 1'b1);
    tick();
    checkOutput("req_ready_drop", int'(cfg_ready), 0);
    checkFrame("req_cap", 4, 2, 3, 1, 0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
    for (int i = 19; i <= 23; i++) begin
      tick();
      checkFrame($sformatf("req_old_%0d", i), 4, 2, i % 4 + 1, (i / 4) % 2 + 1, 0);
      checkOutput($sformatf("req_old_ready_%0d", i), int'(cfg_ready), 0);
    end
    tick();
    checkFrame("req_apply", 6, 3, 1, 1, 1);
    checkOutput("req_apply_ready", int'(cfg_ready), 1);
    for (int j = 1; j <= 18; j++) begin
      tick();
      checkFrame($sformatf("f18_%0d", j), 6, 3, j % 6 + 1, (j / 6) % 3 + 1, int'(j == 18));
    end

    // Zero request clamps to N=2, M=1.
    applyStimulus(1'b1, 4'd0, 2'd0, 1'b1, 1'b1);
    tick();
    checkFrame("clamp_cap", 6, 3, 2, 1, 0);
    checkOutput("clamp_cap_ready", int'(cfg_ready), 0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
    for (int k = 2; k <= 17; k++) begin
      tick();
      checkFrame($sformatf("clamp_old_%0d", k), 6, 3, k % 6 + 1, k / 6 + 1, 0);
    end
    tick();
    checkFrame("clamp_apply", 2, 1, 1, 1, 1);
    checkOutput("clamp_apply_ready", int'(cfg_ready), 1);
    for (int t = 1; t <= 4; t++) begin
      tick();
      checkFrame($sformatf("f2_%0d", t), 2, 1, t % 2 + 1, 1, int'(t % 2 == 0));
    end

    // Capture on the boundary edge waits a full frame; a request while busy is dropped.
    tick();
    checkFrame("bnd_pre", 2, 1, 2, 1, 0);
    applyStimulus(1'b1, 4'd3, 2'd2, 1'b1, 1'b1);
    tick();
    checkFrame("bnd_cap", 2, 1, 1, 1, 1);
    checkOutput("bnd_cap_ready", int'(cfg_ready), 0);
    applyStimulus(1'b1, 4'd5, 2'd1, 1'b1, 1'b1);
    tick();
    checkFrame("bnd_hold", 2, 1, 2, 1, 0);
    checkOutput("bnd_hold_ready", int'(cfg_ready), 0);
    tick();
    checkFrame("bnd_apply", 3, 2, 1, 1, 1);
    checkOutput("bnd_apply_ready", int'(cfg_ready), 1);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
    for (int u = 1; u <= 6; u++) begin
      tick();
      checkFrame($sformatf("f6_%0d", u), 3, 2, u % 3 + 1, (u / 3) % 2 + 1, int'(u == 6));
      checkOutput($sformatf("f6_ready_%0d", u), int'(cfg_ready), 1);
    end

    // Dropping en applies a pending request at once; requests while parked apply next edge.
    tick();
    checkFrame("en_pos", 3, 2, 2, 1, 0);
    applyStimulus(1'b1, 4'd5, 2'd3, 1'b1, 1'b1);
    tick();
    checkFrame("en_cap", 3, 2, 3, 1, 0);
    checkOutput("en_cap_ready", int'(cfg_ready), 0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    checkFrame("en_off", 5, 3, 1, 1, 0);
    checkOutput("en_off_ready", int'(cfg_ready), 1);
    applyStimulus(1'b1, 4'd7, 2'd1, 1'b0, 1'b1);
    tick();
    checkFrame("en_off_cap", 5, 3, 1, 1, 0);
    checkOutput("en_off_cap_ready", int'(cfg_ready), 0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 1'b1);
    tick();
    checkFrame("en_off_apply", 7, 1, 1, 1, 0);
    checkOutput("en_off_apply_ready", int'(cfg_ready), 1);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
    tick();
    checkFrame("en_rise", 7, 1, 1, 1, 1);
    tick();
    checkFrame("en_run1", 7, 1, 2, 1, 0);
    tick();
    checkFrame("en_run2", 7, 1, 3, 1, 0);

    // Reset mid-frame discards the pending request.
    applyStimulus(1'b1, 4'd9, 2'd2, 1'b1, 1'b1);
    tick();
    checkFrame("rst_cap", 7, 1, 4, 1, 0);
    checkOutput("rst_cap_ready", int'(cfg_ready), 0);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    tick();
    checkFrame("rst_mid", 4, 2, 1, 1, 0);
    checkOutput("rst_mid_ready", int'(cfg_ready), 1);
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b1);
    for (int r = 1; r <= 8; r++) begin
      tick();
      checkFrame($sformatf("rst_run_%0d", r), 4, 2, r % 4 + 1, (r / 4) % 2 + 1, int'(r == 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fmdll_div_counter.md
Name: fmdll_div_counter

Overview:
- Frame divider/counter stage of the FMDLL; runs on the DLL output clock (clk_out) and directly feeds the injection-select stage.
- Produces the active divide ratios N and M, the position counters N_counter/M_counter and the divided clocks DIV_N/DIV_M that the select stage decodes into its 2-bit mux select.
- Accepts new N/M settings over a valid/ready handshake and applies them only at a frame boundary, so a frame is never cut short.

Parameters:
- N_DEF, 4, N ratio loaded at reset (2..15).
- M_DEF, 2, M ratio loaded at reset (1..3).

Ports:
- clk  input  1  DLL output clock (clk_out); all logic is rising-edge.
- rst_n  input  1  reset rst_n, synchronous, active-low.
- en  input  1  counting enable; low parks the frame at its start.
- cfg_valid  input  1  new ratio request.
- cfg_ready  output  1  high when a request can be accepted.
- N_cfg  input  4  requested N.
- M_cfg  input  2  requested M.
- N  output  4  active N ratio.
- M  output  2  active M ratio.
- N_counter  output  4  position in the N period, range 1..N.
- M_counter  output  2  position in the M frame, range 1..M.
- DIV_N  output  1  divided clock, period N cycles.
- DIV_M  output  1  divided clock, period N*M cycles.
- frame_start  output  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (rst_n=0 at a rising edge):
  - N=N_DEF, M=M_DEF; N_counter=1, M_counter=1.
  - DIV_N=1, DIV_M=1, cfg_ready=1, frame_start=0.
  - Pending request cleared.
  - Reset overrides everything, including mid-frame or mid-handshake.
- Clamping, applied when a request is captured: N_cfg<2 becomes 2; M_cfg=0 becomes 1.
- Counting while en=1:
  - N_counter increments every cycle; at N it wraps to 1.
  - M_counter increments on each N_counter wrap; when it wraps from M it goes to 1.
  - Frame boundary = the cycle with N_counter==N and M_counter==M.
- Divided clocks, registered from next-state counter values:
  - DIV_N = (N_counter <= (N+1)>>1).
  - DIV_M = (M_counter <= (M+1)>>1).
  - Both are therefore high at frame start and low at each period's end (when M>=2). With M=1, DIV_M stays 1.
- frame_start is 1 in the cycle in which the counters are (1,1) after a wrap or after en rises; 0 otherwise. It is 0 in the cycle immediately after reset.
- Config handshake:
  - Capture occurs when cfg_valid && cfg_ready; the clamped values go into a pending register and cfg_ready drops the next cycle.
  - At the next boundary wrap, pending values load into N/M together with the counters returning to (1,1); cfg_ready returns to 1 that cycle.
  - A capture in the same cycle as a boundary wrap does NOT apply at that wrap; it applies at the following one.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold it.
- en=0:
  - Counters forced to (1,1), DIV_N=1, DIV_M=1, frame_start=0.
  - Any pending values apply immediately on that edge.
  - Handshake is still accepted; while en=0 the captured values apply on the next edge.
  - When en rises, the first counted cycle asserts frame_start.
- No counter may ever leave its range; N/M change only at the (1,1) state.

Decomposition:
- Shared package fmdll_pkg holds:
  - N_W=4, M_W=2.
  - N_MIN=2, M_MIN=1.
  - a clamp function for N/M, reused by the select stage's checker.
- One natural sub-module: fmdll_mod_counter. It is a parametric-width counter running 1..limit with an inc input and a wrap output, instantiated twice: inner N counter, outer M counter clocked by the N wrap.

Test Plan:
- Reset with defaults, en=1, 16 cycles:
  - N_counter sequence is 1,2,3,4,1…
  - M_counter toggles 1,2 every 4 cycles.
  - DIV_N is 1,1,0,0; DIV_M is high 4 cycles then low 4.
  - frame_start fires every 8 cycles.
- Mid-frame request N_cfg=6, M_cfg=3 at N_counter=2, M_counter=1:
  - cfg_ready drops the next cycle.
  - The old frame completes its 8 cycles.
  - Then N=6, M=3 take effect, frame_start fires, and frames are 18 cycles; cfg_ready returns to 1.
- Clamping: N_cfg=0, M_cfg=0 requested → after the boundary, N=2, M=1, DIV_M constant 1, frame length 2.
- Request captured exactly on a boundary cycle → not applied there; applied at the next boundary. A second cfg_valid while cfg_ready=0 is ignored.
- en=0 mid-frame with a pending request → the next edge shows counters (1,1) and the new N/M. When en returns to 1, frame_start pulses on the first counted cycle.
- rst_n=0 mid-frame with a pending request → the next edge shows N=4, M=2, counters (1,1), cfg_ready=1, and the pending request is discarded.
